// File: rtl/wb_pipe_stage_if.sv
// Handshake bundle for the write-back pipeline stage: upstream entry in,
// head entry out, plus the derived write-back port and stall counter.
interface wb_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_c;
    logic [DATA_W-1:0] in_dm_data;
    logic [RD_W-1:0]   in_rd;
    logic              in_regw;
    logic              in_mem2r;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu_c;
    logic [DATA_W-1:0] out_dm_data;
    logic [RD_W-1:0]   out_rd;
    logic              out_regw;
    logic              out_mem2r;

    logic [DATA_W-1:0] wb_data;
    logic              wb_we;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_alu_c, in_dm_data, in_rd, in_regw, in_mem2r, out_ready,
        input  in_ready, out_valid, out_alu_c, out_dm_data, out_rd, out_regw, out_mem2r,
        input  wb_data, wb_we, stall_cnt
    );

    modport slave (
        input  in_valid, in_alu_c, in_dm_data, in_rd, in_regw, in_mem2r, out_ready,
        output in_ready, out_valid, out_alu_c, out_dm_data, out_rd, out_regw, out_mem2r,
        output wb_data, wb_we, stall_cnt
    );
endinterface

// File: rtl/wb_pipe_stage.sv
// Write-back pipeline stage: head register plus optional one-entry skid buffer,
// with register-file write port derivation and a saturating stall counter.
module wb_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    wb_pipe_stage_if.slave bus
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] alu_c;
        logic [DATA_W-1:0] dm_data;
        logic [RD_W-1:0]   rd;
        logic              regw;
        logic              mem2r;
    } entry_t;

    state_t           r_state;
    state_t           w_state_nxt;
    entry_t           r_head;
    entry_t           r_skid;
    entry_t           w_head_nxt;
    entry_t           w_skid_nxt;
    entry_t           w_in_entry;
    logic             r_in_ready;
    logic             w_in_ready;
    logic             w_xfer_in;
    logic             w_out_valid;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in_entry  = {bus.in_alu_c, bus.in_dm_data, bus.in_rd, bus.in_regw, bus.in_mem2r};
    assign w_out_valid = (r_state != ST_EMPTY);
    // Without a skid slot the stage can only accept when the head is free or leaving.
    assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid | bus.out_ready);
    assign w_xfer_in   = bus.in_valid & w_in_ready;

    // Next-state and entry-movement logic; the SKID state is unreachable when SKID=0.
    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_xfer_in) begin
                        w_state_nxt = ST_FULL;
                        w_head_nxt  = w_in_entry;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready) begin
                        if (w_xfer_in) begin
                            w_state_nxt = ST_FULL;
                            w_head_nxt  = w_in_entry;
                        end else begin
                            w_state_nxt = ST_EMPTY;
                        end
                    end else if (w_xfer_in) begin
                        w_state_nxt = ST_SKID;
                        w_skid_nxt  = w_in_entry;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                ST_SKID: begin
                    if (bus.out_ready) begin
                        w_state_nxt = ST_FULL;
                        w_head_nxt  = r_skid;
                    end else begin
                        w_state_nxt = ST_SKID;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State, entry storage, registered ready and stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_head      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_head     <= w_head_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != ST_SKID);
            if (w_out_valid && !bus.out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = w_out_valid;
    assign bus.out_alu_c   = r_head.alu_c;
    assign bus.out_dm_data = r_head.dm_data;
    assign bus.out_rd      = r_head.rd;
    assign bus.out_regw    = r_head.regw;
    assign bus.out_mem2r   = r_head.mem2r;
    assign bus.wb_data     = r_head.mem2r ? r_head.dm_data : r_head.alu_c;
    assign bus.wb_we       = w_out_valid & r_head.regw & (r_head.rd != {RD_W{1'b0}});
    assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench: directed vector table on the skid variant, hand sequences
// for stall saturation and the combinational-ready variant, then random FIFO traffic.
module tb_wb_pipe_stage;

    localparam int N_RAND = 10000;
    localparam int NV     = 17;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_errors;

    wb_pipe_stage_if #(.DATA_W(32), .RD_W(5), .CNT_W(4))  if_a ();
    wb_pipe_stage_if #(.DATA_W(32), .RD_W(5), .CNT_W(16)) if_b ();

    wb_pipe_stage #(.DATA_W(32), .RD_W(5), .SKID(1), .CNT_W(4)) u_dut_skid (
        .clk(clk), .rst(rst), .flush(flush), .bus(if_a)
    );
    wb_pipe_stage #(.DATA_W(32), .RD_W(5), .SKID(0), .CNT_W(16)) u_dut_noskid (
        .clk(clk), .rst(rst), .flush(flush), .bus(if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [4:0]  rd;
        logic        regw;
        logic        m2r;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic        chk_data;
        logic [31:0] e_alu;
        logic [31:0] e_wbd;
        logic        e_we;
        logic [3:0]  e_stall;
    } vec_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] dm;
        logic [4:0]  rd;
        logic        regw;
        logic        m2r;
    } ent_t;

    vec_t vecs [NV];
    ent_t q_a [$];
    ent_t q_b [$];

    function automatic vec_t mkv(input logic r, input logic f, input logic iv,
                                 input logic [31:0] alu, input logic [31:0] dm,
                                 input logic [4:0] rd, input logic rw, input logic m2r,
                                 input logic ordy, input logic ov, input logic ir,
                                 input logic cd, input logic [31:0] ealu,
                                 input logic [31:0] ewbd, input logic ewe,
                                 input logic [3:0] est);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.alu = alu; v.dm = dm; v.rd = rd;
        v.regw = rw; v.m2r = m2r; v.ordy = ordy; v.e_ov = ov; v.e_ir = ir;
        v.chk_data = cd; v.e_alu = ealu; v.e_wbd = ewbd; v.e_we = ewe; v.e_stall = est;
        return v;
    endfunction

    function automatic ent_t mk_entry(input int seq);
        ent_t e;
        logic [31:0] s;
        s      = 32'(seq);
        e.alu  = s ^ 32'hA500_0000;
        e.dm   = {s[15:0], ~s[15:0]};
        e.rd   = s[4:0];
        e.regw = s[5];
        e.m2r  = s[6];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks = n_checks + 1;
        if (got !== want) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic drive_a(input logic iv, input logic [31:0] alu, input logic [31:0] dm,
                           input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic ordy);
        if_a.in_valid = iv; if_a.in_alu_c = alu; if_a.in_dm_data = dm; if_a.in_rd = rd;
        if_a.in_regw = rw; if_a.in_mem2r = m2r; if_a.out_ready = ordy;
    endtask

    task automatic drive_b(input logic iv, input logic [31:0] alu, input logic [31:0] dm,
                           input logic [4:0] rd, input logic rw, input logic m2r,
                           input logic ordy);
        if_b.in_valid = iv; if_b.in_alu_c = alu; if_b.in_dm_data = dm; if_b.in_rd = rd;
        if_b.in_regw = rw; if_b.in_mem2r = m2r; if_b.out_ready = ordy;
    endtask

    initial begin
        int   sent_a, recv_a, bad_a, sent_b, recv_b, bad_b;
        ent_t e_a, e_b, w;

        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        flush = 1'b0;
        drive_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);

        //            rst   flush iv    alu          dm           rd     rw    m2r   ordy  ov    ir    cd    e_alu        e_wbd        we    stall
        vecs[0]  = mkv(1'b1, 1'b0, 1'b1, 32'h77,      32'h0,       5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,       32'h0,       1'b0, 4'd0);
        vecs[1]  = mkv(1'b0, 1'b0, 1'b1, 32'h11,      32'h22,      5'd3,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11,      32'h11,      1'b1, 4'd0);
        vecs[2]  = mkv(1'b0, 1'b0, 1'b1, 32'h33,      32'hAB,      5'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33,      32'hAB,      1'b0, 4'd0);
        vecs[3]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,       32'h0,       5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33,      32'hAB,      1'b0, 4'd1);
        vecs[4]  = mkv(1'b0, 1'b0, 1'b1, 32'h44,      32'h55,      5'd7,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h33,      32'hAB,      1'b0, 4'd2);
        vecs[5]  = mkv(1'b0, 1'b0, 1'b1, 32'h99,      32'h0,       5'd9,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h33,      32'hAB,      1'b0, 4'd3);
        vecs[6]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,       32'h0,       5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44,      32'h44,      1'b1, 4'd3);
        vecs[7]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,       32'h0,       5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h44,      32'h44,      1'b0, 4'd3);
        vecs[8]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,       32'h0,       5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44,      32'h44,      1'b0, 4'd3);
        vecs[9]  = mkv(1'b0, 1'b0, 1'b1, 32'hA1,      32'h0,       5'd1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1,      32'hA1,      1'b1, 4'd3);
        vecs[10] = mkv(1'b0, 1'b0, 1'b1, 32'hB2,      32'h0,       5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA1,      32'hA1,      1'b1, 4'd4);
        vecs[11] = mkv(1'b0, 1'b1, 1'b1, 32'hC3,      32'h0,       5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       32'h0,       1'b0, 4'd5);
        vecs[12] = mkv(1'b0, 1'b0, 1'b0, 32'h0,       32'h0,       5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,       32'h0,       1'b0, 4'd5);
        vecs[13] = mkv(1'b0, 1'b0, 1'b1, 32'hD4,      32'h0,       5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD4,      32'hD4,      1'b1, 4'd5);
        vecs[14] = mkv(1'b0, 1'b0, 1'b1, 32'hE5,      32'h0,       5'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hD4,      32'hD4,      1'b1, 4'd6);
        vecs[15] = mkv(1'b1, 1'b0, 1'b1, 32'hF6,      32'h0,       5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,       32'h0,       1'b0, 4'd0);
        vecs[16] = mkv(1'b0, 1'b0, 1'b0, 32'h0,       32'h0,       5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0,       32'h0,       1'b0, 4'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            flush = vecs[i].flush;
            drive_a(vecs[i].iv, vecs[i].alu, vecs[i].dm, vecs[i].rd, vecs[i].regw,
                    vecs[i].m2r, vecs[i].ordy);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(if_a.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_in_ready", i),  32'(if_a.in_ready),  32'(vecs[i].e_ir));
            check($sformatf("v%0d_wb_we", i),     32'(if_a.wb_we),     32'(vecs[i].e_we));
            check($sformatf("v%0d_stall_cnt", i), 32'(if_a.stall_cnt), 32'(vecs[i].e_stall));
            if (vecs[i].chk_data) begin
                check($sformatf("v%0d_out_alu_c", i), if_a.out_alu_c, vecs[i].e_alu);
                check($sformatf("v%0d_wb_data", i),   if_a.wb_data,   vecs[i].e_wbd);
            end
        end

        // Stall counter saturation on the 4-bit counter.
        @(negedge clk);
        drive_a(1'b1, 32'h5A, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("sat_load_valid", 32'(if_a.out_valid), 32'd1);
        check("sat_start_cnt", 32'(if_a.stall_cnt), 32'd0);
        @(negedge clk);
        drive_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 14) check("sat_cnt_14", 32'(if_a.stall_cnt), 32'd14);
            if (k == 15) check("sat_cnt_15", 32'(if_a.stall_cnt), 32'd15);
            if (k == 20) begin
                check("sat_cnt_20", 32'(if_a.stall_cnt), 32'd15);
                check("sat_head_held", if_a.out_alu_c, 32'h5A);
            end
        end

        // Combinational-ready variant.
        @(negedge clk);
        drive_b(1'b1, 32'h11, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("b_first_valid", 32'(if_b.out_valid), 32'd1);
        check("b_first_alu", if_b.out_alu_c, 32'h11);
        check("b_first_we", 32'(if_b.wb_we), 32'd1);
        check("b_first_wbd", if_b.wb_data, 32'h11);
        @(negedge clk);
        drive_b(1'b1, 32'h22, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0);
        #1;
        check("b_ready_blocked", 32'(if_b.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("b_hold_alu", if_b.out_alu_c, 32'h11);
        check("b_stall", 32'(if_b.stall_cnt), 32'd1);
        @(negedge clk);
        if_b.out_ready = 1'b1;
        #1;
        check("b_ready_passthru", 32'(if_b.in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("b_replace_alu", if_b.out_alu_c, 32'h22);
        @(negedge clk);
        drive_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("b_drain_valid", 32'(if_b.out_valid), 32'd0);

        // Random traffic on both variants, scoreboarded against a FIFO model.
        @(negedge clk);
        rst = 1'b1;
        drive_a(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        drive_b(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sent_a = 0; recv_a = 0; bad_a = 0;
        sent_b = 0; recv_b = 0; bad_b = 0;
        for (int cyc = 0; cyc < 40000 && (recv_a < N_RAND || recv_b < N_RAND); cyc++) begin
            @(negedge clk);
            e_a = mk_entry(sent_a);
            e_b = mk_entry(sent_b + 32'h100000);
            drive_a((sent_a < N_RAND) && ($urandom_range(3) != 0), e_a.alu, e_a.dm, e_a.rd,
                    e_a.regw, e_a.m2r, ($urandom_range(3) != 0));
            drive_b((sent_b < N_RAND) && ($urandom_range(3) != 0), e_b.alu, e_b.dm, e_b.rd,
                    e_b.regw, e_b.m2r, ($urandom_range(3) != 0));
            #1;
            if (if_a.out_valid && if_a.out_ready) begin
                if (q_a.size() == 0) bad_a++;
                else begin
                    w = q_a.pop_front();
                    if ({if_a.out_alu_c, if_a.out_dm_data, if_a.out_rd, if_a.out_regw,
                         if_a.out_mem2r} !== w) bad_a++;
                end
                recv_a++;
            end
            if (if_a.in_valid && if_a.in_ready) begin
                q_a.push_back(e_a);
                sent_a++;
            end
            if (if_b.out_valid && if_b.out_ready) begin
                if (q_b.size() == 0) bad_b++;
                else begin
                    w = q_b.pop_front();
                    if ({if_b.out_alu_c, if_b.out_dm_data, if_b.out_rd, if_b.out_regw,
                         if_b.out_mem2r} !== w) bad_b++;
                end
                recv_b++;
            end
            if (if_b.in_valid && if_b.in_ready) begin
                q_b.push_back(e_b);
                sent_b++;
            end
        end
        check("rand_skid1_mismatches", 32'(bad_a), 32'd0);
        check("rand_skid1_received", 32'(recv_a), 32'(N_RAND));
        check("rand_skid0_mismatches", 32'(bad_b), 32'd0);
        check("rand_skid0_received", 32'(recv_b), 32'(N_RAND));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_pipe_stage.md
WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU-result and memory-data fields.
REQ-002 Parameter RD_W, default 5, width of the destination-register index.
REQ-003 Parameter SKID, default 1; 1 adds a one-entry skid buffer, 0 uses a single register with a combinational ready path.
REQ-004 Parameter CNT_W, default 16, width of the stall counter.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset; synchronous and active-high.
REQ-007 Port flush  input  1  discards all held entries (branch or exception kill).
REQ-008 Port in_valid  input  1  upstream presents a valid entry.
REQ-009 Port in_ready  output  1  stage accepts an entry this cycle.
REQ-010 Port in_alu_c / in_dm_data  input  DATA_W each  ALU result and data-memory read data.
REQ-011 Port in_rd  input  RD_W  destination register index.
REQ-012 Port in_regw / in_mem2r  input  1 each  register-write enable and memory-to-register select.
REQ-013 Port out_valid  output  1  stage holds a valid entry.
REQ-014 Port out_ready  input  1  downstream consumes the entry this cycle.
REQ-015 Port out_alu_c / out_dm_data / out_rd / out_regw / out_mem2r  output  registered copies of the head entry.
REQ-016 Port wb_data  output  DATA_W  out_mem2r ? out_dm_data : out_alu_c, combinational from head.
REQ-017 Port wb_we  output  1  out_valid & out_regw & (out_rd != 0).
REQ-018 Port stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-019 Transfer in: in_valid & in_ready on a rising edge; transfer out: out_valid & out_ready on a rising edge.
REQ-020 SKID=1 states: EMPTY, FULL (head only), SKID (head plus skid entry); in_ready = (state != SKID), registered.
REQ-021 EMPTY: in_valid -> FULL, head loaded; otherwise stay.
REQ-022 FULL: in_valid & out_ready -> FULL with head replaced by input; !in_valid & out_ready -> EMPTY; in_valid & !out_ready -> SKID with input captured in skid; otherwise stay.
REQ-023 SKID: out_ready -> FULL with head loaded from skid; otherwise stay, head and skid unchanged.
REQ-024 SKID=0: in_ready = !out_valid | out_ready (combinational); head loads on any transfer in; out_valid clears on transfer out without transfer in.
REQ-025 Latency: an entry accepted at edge N appears on out_* at edge N with out_valid=1 if the stage was EMPTY or the head drained in the same cycle; ordering is strictly FIFO and no entry is dropped or duplicated.
REQ-026 out_valid = (state != EMPTY); all out_* fields hold their last value when EMPTY.
REQ-027 flush=1 forces EMPTY at the next edge, invalidating head and skid; an input offered in the same cycle is discarded; data registers need not clear.
REQ-028 stall_cnt increments by 1 per stalled cycle, saturates at all-ones, and never wraps.
REQ-029 wb_we is 0 whenever out_valid=0, or the destination is register 0.

Reset
REQ-030 rst=1 at an edge forces state EMPTY, all out_* fields to 0, stall_cnt to 0, and in_ready to 1 (SKID=1) from the next cycle.
REQ-031 rst has priority over flush and all handshakes; an entry offered during rst is discarded.
REQ-032 Reset asserted while in SKID drops both entries, with no residual out_valid after release.

Verification
REQ-033 Reset, then in_valid=1, alu_c=0x11, rd=3, regw=1, out_ready=1 -> next cycle out_valid=1, out_alu_c=0x11, wb_we=1, wb_data=0x11.
REQ-034 Head rd=0, regw=1, mem2r=1, dm=0xAB -> wb_data=0xAB, wb_we=0.
REQ-035 SKID=1, out_ready=0, push A then B -> state SKID, in_ready=0, out=A; raise out_ready for 2 cycles -> A then B delivered, state EMPTY.
REQ-036 In SKID with flush=1 and in_valid=1 -> next cycle out_valid=0, in_ready=1, offered entry never appears.
REQ-037 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 and stays 15.
REQ-038 Random valid/ready traffic, 10k entries with SKID=0 and SKID=1 -> output sequence equals input sequence exactly.
